// File: rtl/cpu_wb_cla_mul.sv
// cpu_wb_cla_mul: registered unsigned shift-and-add multiplier summed through a chain of two-level CLA adders.
// Define CLA_MUL_INREG_EN to capture the operands in input registers ahead of the array (latency 2).
module cpu_wb_cla_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   s_o
);
    localparam int NB = W / 4;
    logic [W-1:0]  g, p, c;
    logic [NB-1:0] bg, bp;
    logic [NB:0]   bc;
    logic          t;
    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        for (int k = 0; k < NB; k++) begin
            bg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            bp[k] = &p[4*k +: 4];
        end
        // Each block carry is a flat sum of products over group P/G; carry-in is 0.
        bc = '0;
        t  = 1'b0;
        for (int k = 1; k <= NB; k++) begin
            for (int j = 0; j < k; j++) begin
                t = bg[j];
                for (int m = j + 1; m < k; m++) t = t & bp[m];
                bc[k] = bc[k] | t;
            end
        end
        for (int k = 0; k < NB; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
        s_o = {bc[NB], p ^ c};
    end
endmodule

module cpu_wb_cla_mul #(
    parameter int MULTICAND_WID  = 32,
    parameter int MULTIPLIER_WID = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [MULTICAND_WID-1:0]              multicand,
    input  logic [MULTIPLIER_WID-1:0]             multiplier,
    output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] product
);
    localparam int A  = MULTICAND_WID;
    localparam int B  = MULTIPLIER_WID;
    localparam int PW = A + B;
    logic [A-1:0]  mc;
    logic [B-1:0]  mp;
    logic [PW-1:0] acc [B];
    logic [PW-1:0] product_d, product_q;
`ifdef CLA_MUL_INREG_EN
    logic [A-1:0] mc_q;
    logic [B-1:0] mp_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_q <= '0;
            mp_q <= '0;
        end else begin
            mc_q <= multicand;
            mp_q <= multiplier;
        end
    end
    assign mc = mc_q;
    assign mp = mp_q;
`else
    assign mc = multicand;
    assign mp = multiplier;
`endif
    assign acc[0] = PW'(mc & {A{mp[0]}});
    // Bits below row i are final; only the A-bit window at i is added, its carry-out becomes bit i+A.
    for (genvar i = 1; i < B; i++) begin : g_row
        logic [A:0] s;
        cpu_wb_cla_add #(.W(A)) u_add (
            .a_i(acc[i-1][i +: A]),
            .b_i(mc & {A{mp[i]}}),
            .s_o(s)
        );
        assign acc[i] = PW'({s, acc[i-1][i-1:0]});
    end
    assign product_d = acc[B-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) product_q <= '0;
        else        product_q <= product_d;
    end
    assign product = product_q;
endmodule

// File: tb/tb_cpu_wb_cla_mul.sv
// tb_cpu_wb_cla_mul: directed self-checking bench for cpu_wb_cla_mul (32x32), both latency builds.
module tb_cpu_wb_cla_mul;
`ifdef CLA_MUL_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = 32'd5;
    logic [31:0] b = 32'd7;
    logic [63:0] product;
    int checks = 0;
    int errors = 0;

    cpu_wb_cla_mul #(.MULTICAND_WID(32), .MULTIPLIER_WID(32)) dut (
        .clk(clk), .rst_n(rst_n), .multicand(a), .multiplier(b), .product(product)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a = 32'd5;
        b = 32'd7;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checks++;
            if (product !== 64'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", k, product);
            end
        end
        rst_n = 1'b1;
        tick(LAT - 1);
        checks++;
        if (product !== 64'd0) begin
            errors++;
            $display("FAIL reset_first_edges: got %h expected 0", product);
        end
        tick(1);
        checks++;
        if (product !== 64'd35) begin
            errors++;
            $display("FAIL reset_5x7: got %h expected %h", product, 64'd35);
        end
    endtask

    task automatic test_ramp;
        logic [63:0] exp_v;
        for (int n = 0; n <= 30; n++) begin
            a = n;
            b = n;
            tick(1);
            if (n >= LAT - 1) begin
                exp_v = 64'((n - LAT + 1) * (n - LAT + 1));
                checks++;
                if (product !== exp_v) begin
                    errors++;
                    $display("FAIL ramp[%0d]: got %h expected %h", n, product, exp_v);
                end
            end
        end
        tick(LAT - 1);
        checks++;
        if (product !== 64'h384) begin
            errors++;
            $display("FAIL ramp_end: got %h expected %h", product, 64'h384);
        end
    endtask

    task automatic run_pair(input string nm, input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] exp_v);
        a = x;
        b = y;
        tick(LAT);
        checks++;
        if (product !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, product, exp_v);
        end
    endtask

    task automatic test_directed;
        run_pair("dir_7fff_7f", 32'h7FFF, 32'h7F, 64'h3F7F81);
        run_pair("dir_8000_f0", 32'h8000, 32'hF0, 64'h780000);
        run_pair("dir_8ff0_f0", 32'h8FF0, 32'hF0, 64'h86F100);
        run_pair("dir_7ff0_f7", 32'h7FF0, 32'hF7, 64'h7B7090);
        run_pair("dir_ffff_ff", 32'hFFFF, 32'hFF, 64'hFEFF01);
    endtask

    task automatic test_carry;
        run_pair("carry_max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        run_pair("carry_max_1", 32'hFFFFFFFF, 32'h1, 64'h00000000FFFFFFFF);
        run_pair("carry_0_max", 32'h0, 32'hFFFFFFFF, 64'h0);
        run_pair("carry_1_max", 32'h1, 32'hFFFFFFFF, 64'h00000000FFFFFFFF);
    endtask

    task automatic test_back_to_back;
        logic [31:0] xs [4] = '{32'h3, 32'h10, 32'hABCD, 32'h12345678};
        logic [31:0] ys [4] = '{32'h4, 32'h10, 32'h2, 32'h10};
        logic [63:0] es [4] = '{64'hC, 64'h100, 64'h1579A, 64'h123456780};
        for (int k = 0; k < 4 + LAT - 1; k++) begin
            if (k < 4) begin
                a = xs[k];
                b = ys[k];
            end
            tick(1);
            if (k >= LAT - 1) begin
                checks++;
                if (product !== es[k-LAT+1]) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got %h expected %h", k - LAT + 1, product, es[k-LAT+1]);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        run_pair("async_pre", 32'hFFFF, 32'hFF, 64'hFEFF01);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (product !== 64'd0) begin
            errors++;
            $display("FAIL async_clear: got %h expected 0", product);
        end
        tick(1);
        checks++;
        if (product !== 64'd0) begin
            errors++;
            $display("FAIL async_hold: got %h expected 0", product);
        end
        rst_n = 1'b1;
        run_pair("async_recover", 32'hFFFF, 32'hFF, 64'hFEFF01);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_directed();
        test_carry();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
